// File: rtl/sync_up_counter_modn_pkg.sv
// counter_pkg: shared limits, parameter checks and next-state op encoding for the counters library.
package counter_pkg;
  localparam int MAX_WIDTH = 16;
  typedef enum logic [1:0] {OP_HOLD, OP_COUNT, OP_WRAP, OP_LOAD} count_op_e;
  function automatic int clog2(input int v);
    int r = 0;
    for (int n = v - 1; n > 0; n = n >> 1) r++;
    return r;
  endfunction
  function automatic bit modulus_ok(input int w, input int m);
    return w >= 1 && w <= MAX_WIDTH && m >= 2 && clog2(m) <= w;
  endfunction
endpackage

// File: rtl/sync_up_counter_modn_if.sv
// sync_up_counter_modn_if: control and count bus of the mod-N up counter.
// COUNTER_OVF_STICKY_EN adds the ovf/ovf_clr pair.
interface sync_up_counter_modn_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             tc;
  logic             wrap;
`ifdef COUNTER_OVF_STICKY_EN
  logic             ovf;
  logic             ovf_clr;
`endif
  modport master (
    output en, load, d,
    input  q, q_bar, tc, wrap
`ifdef COUNTER_OVF_STICKY_EN
    , output ovf_clr
    , input  ovf
`endif
  );
  modport slave (
    input  en, load, d,
    output q, q_bar, tc, wrap
`ifdef COUNTER_OVF_STICKY_EN
    , input  ovf_clr
    , output ovf
`endif
  );
endinterface

// File: rtl/sync_up_counter_modn_t_ff_cell.sv
// t_ff_cell: toggle flip-flop with asynchronous clear and complementary outputs.
module t_ff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q,
  output logic q_bar
);
  logic q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= 1'b0;
    else q_q <= q_q ^ t;
  assign q     = q_q;
  assign q_bar = ~q_q;
endmodule

// File: rtl/sync_up_counter_modn.sv
// sync_up_counter_modn: synchronous modulo-N up counter built from toggle cells.
// COUNTER_OVF_STICKY_EN adds a sticky overflow flag set on every wrap.
module sync_up_counter_modn
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  sync_up_counter_modn_if.slave bus
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD  = (WIDTH + 1)'(MODULUS);
  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_param
    $error("sync_up_counter_modn: MODULUS %0d out of range for WIDTH %0d", MODULUS, WIDTH);
  end
  count_op_e        op;
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_bar, t;
  logic             wrap_q, wrap_d;
  always_comb begin
    op     = bus.load ? OP_LOAD : !bus.en ? OP_HOLD : cnt_q == LAST ? OP_WRAP : OP_COUNT;
    cnt_d  = op == OP_LOAD  ? ({1'b0, bus.d} < MOD ? bus.d : '0) :
             op == OP_COUNT ? cnt_q + WIDTH'(1) :
             op == OP_WRAP  ? '0 : cnt_q;
    wrap_d = op == OP_WRAP;
  end
  // each cell flips exactly the bits that differ between present and next count
  assign t = cnt_q ^ cnt_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .t    (t[i]),
      .q    (cnt_q[i]),
      .q_bar(cnt_bar[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wrap_q <= 1'b0;
    else wrap_q <= wrap_d;
`ifdef COUNTER_OVF_STICKY_EN
  logic ovf_q, ovf_d;
  // a wrap in the same cycle as a clear keeps the flag set
  assign ovf_d = wrap_d | (ovf_q & ~bus.ovf_clr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  assign bus.ovf = ovf_q;
`endif
  assign bus.q     = cnt_q;
  assign bus.q_bar = cnt_bar;
  assign bus.tc    = op == OP_WRAP;
  assign bus.wrap  = wrap_q;
endmodule
